inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 120 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues sequential reads to a one-cycle
// instruction memory and buffers the returned words in a 2-entry FIFO that
// feeds decode.
// A redirect flushes all buffered and in-flight work and restarts fetch.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  // Fetch and in-flight tracking
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] infl_pc_q, infl_pc_d;

  // FIFO: entry 0 is always the head, entry 1 sits behind it
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
  logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;

  logic        pop;
  logic        push;
  logic [1:0]  slot;
  logic [2:0]  occupancy;

  assign inst_valid = (count_q != 2'd0);
  assign inst       = ins0_q;
  assign inst_pc    = pc0_q;
  assign imem_addr  = {fetch_pc_q[31:2], 2'b00};

  assign pop  = inst_valid & inst_ready;
  // A response landing in a redirect cycle belongs to the old stream
  assign push = inflight_q & ~redirect;

  // Entries already owned (stored plus returning) after this cycle's pop;
  // count_q >= pop so this never underflows
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Gated by rst_n so no read is requested while reset is held
  assign imem_en = rst_n & ~redirect & (occupancy < 3'd2);

  // Tail slot for the incoming word, after any head shift from a pop
  assign slot = count_q - {1'b0, pop};

  // Next-state computation for fetch pointer and FIFO contents
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = imem_en;
    infl_pc_d  = infl_pc_q;
    count_d    = count_q;
    pc0_d      = pc0_q;
    ins0_d     = ins0_q;
    pc1_d      = pc1_q;
    ins1_d     = ins1_q;

    if (imem_en) begin
      infl_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect) begin
      // A same-cycle pop is already consumed by decode; everything else drops
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = 2'd0;
    end else begin
      if (pop) begin
        pc0_d  = pc1_q;
        ins0_d = ins1_q;
      end
      if (push) begin
        if (slot == 2'd0) begin
          pc0_d  = infl_pc_q;
          ins0_d = imem_dout;
        end else begin
          pc1_d  = infl_pc_q;
          ins1_d = imem_dout;
        end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Control state and the visible head entry, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= START_PC;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      pc0_q      <= START_PC;
      ins0_q     <= NOP_INST;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      ins0_q     <= ins0_d;
    end
  end

  // Data-only registers; their contents are meaningless until written
  always_ff @(posedge clk) begin
    infl_pc_q <= infl_pc_d;
    pc1_q     <= pc1_d;
    ins1_q    <= ins1_d;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue against a queue-based
// transaction model of the fetch/decode handshake.
module tb_inst_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_pend_pc;

  inst_fetch_queue #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  // Memory: word for the address one cycle after the read; junk otherwise
  always @(posedge clk) begin
    if (imem_en) imem_dout <= mem_word(imem_addr);
    else         imem_dout <= $urandom;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    {31'b0, imem_en},    32'd0);
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
    check({tag, "_inst"},  inst,                NOP_INST);
    check({tag, "_pc"},    inst_pc,             RESET_PC);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 1'b0;
    m_pc   = RESET_PC;
  endtask

  // One clock cycle: drive after negedge, check, then advance the model
  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy);
    logic        e_en;
    logic        e_vld;
    logic        e_pop;
    logic [31:0] d;
    e_en  = 1'b0;
    e_vld = 1'b0;
    e_pop = 1'b0;
    redirect    = rd;
    redirect_pc = rpc;
    inst_ready  = rdy;
    #1;
    if (!rst_n) begin
      check_reset_outputs("rst");
    end else begin
      e_vld = (mq.size() != 0);
      e_pop = e_vld & rdy;
      e_en  = !rd && ((mq.size() + int'(m_pend) - int'(e_pop)) < 2);
      check("imem_en", {31'b0, imem_en}, {31'b0, e_en});
      if (e_en) check("imem_addr", imem_addr, m_pc);
      check("inst_valid", {31'b0, inst_valid}, {31'b0, e_vld});
      if (e_vld) begin
        check("inst_pc", inst_pc, mq[0].pc);
        check("inst", inst, mq[0].w);
      end
    end
    d = imem_dout;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (rd) begin
      mq.delete();
      m_pend = 1'b0;
      m_pc   = {rpc[31:2], 2'b00};
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_pend) mq.push_back('{pc: m_pend_pc, w: d});
      m_pend = e_en;
      if (e_en) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  // Reset asserted between clock edges must clear outputs without a clock
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    logic        rd;
    logic        rdy;
    logic [31:0] rpc;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    inst_ready  = 1'b0;
    model_reset();
    m_pend_pc   = 32'd0;
    @(negedge clk);

    // Reset held, then streaming with ready high
    repeat (3) cycle(1'b0, 32'd0, 1'b1);
    rst_n = 1'b1;
    repeat (14) cycle(1'b0, 32'd0, 1'b1);

    // Backpressure from the first valid, then release
    rst_n = 1'b0;
    repeat (2) cycle(1'b0, 32'd0, 1'b0);
    rst_n = 1'b1;
    repeat (12) cycle(1'b0, 32'd0, 1'b0);
    check("hold_pc", inst_pc, RESET_PC);
    repeat (6) cycle(1'b0, 32'd0, 1'b1);

    // Redirect with the queue filling and a fetch in flight
    repeat (2) cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'h1000_0002, 1'b0);
    repeat (5) cycle(1'b0, 32'd0, 1'b1);

    // Redirect with a same-cycle pop
    repeat (3) cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'h2000_0040, 1'b1);
    repeat (5) cycle(1'b0, 32'd0, 1'b1);

    // Address wrap
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (6) cycle(1'b0, 32'd0, 1'b1);

    // Back-to-back redirects
    cycle(1'b1, 32'h3000_0100, 1'b1);
    cycle(1'b1, 32'h5000_0200, 1'b0);
    repeat (5) cycle(1'b0, 32'd0, 1'b1);

    // Asynchronous reset mid-stream with the queue full
    repeat (3) cycle(1'b0, 32'd0, 1'b0);
    async_reset();
    repeat (2) cycle(1'b0, 32'd0, 1'b1);
    rst_n = 1'b1;
    repeat (6) cycle(1'b0, 32'd0, 1'b1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rd  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      cycle(rd, rpc, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
